// File: rtl/board_pkg.sv
// Shared definitions for the board row-clear block: default board size,
// the row bitmap type and the controller state encoding.
`timescale 1ns/1ps
package board_pkg;

  localparam int BOARD_COLS_DEF = 12;
  localparam int BOARD_ROWS_DEF = 18;

  typedef logic [15:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2
  } brc_state_t;

endpackage

// File: rtl/board_row_clear.sv
// Board-state owner for the falling-block game. Accepts lock events, sets the
// locked cell, then scans bottom-up removing full rows by shifting the rows
// above them down. Reports cleared-line count and a sticky game-over flag.
// Optional feature macro: BOARD_ROW_CLEAR_SCORE_EN enables the saturating
// lines_cleared counter; without it lines_cleared is tied to 0.
`timescale 1ns/1ps
module board_row_clear
  import board_pkg::*;
#(
  parameter int BOARD_COLS = BOARD_COLS_DEF,
  parameter int BOARD_ROWS = BOARD_ROWS_DEF
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        lock_valid,
  input  logic [5:0]  lock_x,
  input  logic [6:0]  lock_y,
  output logic        lock_ready,
  input  logic [6:0]  rd_row,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        clear_pulse,
  output logic [15:0] lines_cleared,
  output logic        game_over
);

  localparam int AW = (BOARD_ROWS > 1) ? $clog2(BOARD_ROWS) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(BOARD_ROWS - 1);
  localparam logic [6:0] ROWS_L = 7'(BOARD_ROWS);
  localparam logic [5:0] COLS_L = 6'(BOARD_COLS);
  localparam row_t COL_MASK = (BOARD_COLS >= 16) ? 16'hFFFF
                                                 : row_t'((17'h1 << BOARD_COLS) - 17'h1);

  row_t          board [BOARD_ROWS];
  brc_state_t    state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] sh;
  logic          row_full;
  logic          clear_evt;
  logic          lock_in_range;

  assign row_full      = (board[ptr] & COL_MASK) == COL_MASK;
  assign clear_evt     = (state == SCAN) && row_full;
  assign lock_in_range = (lock_x < COLS_L) && (lock_y < ROWS_L);
  assign lock_ready    = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rd_data       = (rd_row < ROWS_L) ? board[rd_row[AW-1:0]] : 16'h0000;

  // Controller: cell write on lock, bottom-up scan, and row-by-row shift down
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      sh          <= '0;
      clear_pulse <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < BOARD_ROWS; i++) begin
        board[i] <= '0;
      end
    end else begin
      clear_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_valid && lock_in_range) begin
            board[lock_y[AW-1:0]][lock_x[3:0]] <= 1'b1;
            ptr   <= LAST_ROW;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (clear_evt) begin
            sh          <= ptr;
            clear_pulse <= 1'b1;
            state       <= SHIFT;
          end else if (ptr != '0) begin
            ptr <= ptr - AW'(1);
          end else begin
            state <= IDLE;
            if (board[0] != '0) begin
              game_over <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (sh == '0) begin
            board[0] <= '0;
            state    <= SCAN;
          end else begin
            board[sh] <= board[sh - AW'(1)];
            sh        <= sh - AW'(1);
            if (sh == AW'(1)) begin
              board[0] <= '0;
              state    <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOARD_ROW_CLEAR_SCORE_EN
  logic [15:0] score_q;

  // Saturating count of removed rows, stepped with each detected full row
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= 16'h0000;
    end else if (clear_evt && (score_q != 16'hFFFF)) begin
      score_q <= score_q + 16'd1;
    end
  end

  assign lines_cleared = score_q;
`else
  assign lines_cleared = 16'h0000;
`endif

endmodule

// File: doc/board_row_clear.md
# board_row_clear

Board-state owner that sits downstream of the falling-block game logic. It accepts lock events, each naming the cell where a block came to rest, and sets that cell in a row-bitmap board. It then scans the board bottom-up, removes every full row by shifting the rows above it down, and reports cleared-line count and game-over. Its read port supplies row bitmaps to the game logic's collision check and to the renderer.

## Interface
- BOARD_COLS, 12, playable columns (x = 0..BOARD_COLS-1), max 16
- BOARD_ROWS, 18, playable rows (y = 0 top .. BOARD_ROWS-1 bottom), max 64
- frame_clk  in  1  sole clock
- Reset_n  in  1  asynchronous, active-low reset
- lock_valid  in  1  lock request; held with lock_x/lock_y until accepted
- lock_x  in  6  column of locked cell
- lock_y  in  7  row of locked cell
- lock_ready  out  1  high only in IDLE; a lock is accepted on an edge where lock_valid && lock_ready
- rd_row  in  7  combinational read address
- rd_data  out  16  row bitmap for rd_row; bit x = cell occupied; 0 if rd_row >= BOARD_ROWS
- busy  out  1  high in SCAN or SHIFT
- clear_pulse  out  1  one-cycle pulse per removed row
- lines_cleared  out  16  total rows removed since reset, saturating at 16'hFFFF
- game_over  out  1  sticky, set when a scan finishes with row 0 non-empty

## Operation
- Storage: BOARD_ROWS x 16-bit rows. Bits >= BOARD_COLS are always 0. A row is full when bits [BOARD_COLS-1:0] are all 1.
- FSM states: IDLE, SCAN, SHIFT.
- IDLE: on an accepted lock with lock_x < BOARD_COLS and lock_y < BOARD_ROWS, OR-set the cell, set ptr = BOARD_ROWS-1, and go to SCAN.
  - An out-of-range lock is consumed without a write and the FSM stays in IDLE.
  - A lock onto an already-set cell is harmless: the bit stays 1 and the scan still runs.
- SCAN: evaluate row ptr.
  - Full: set sh = ptr, go to SHIFT, and pulse clear_pulse this cycle.
  - Not full, ptr > 0: decrement ptr.
  - Not full, ptr == 0: go to IDLE and set game_over if row 0 != 0.
- SHIFT: each cycle, row[sh] <= row[sh-1] and sh decrements.
  - On the cycle sh == 1, row[0] <= 0 in the same cycle.
  - If entered with sh == 0, clear row 0 in one cycle.
  - Then return to SCAN with ptr unchanged, so the row shifted into ptr is rechecked.
- lines_cleared increments on every clear_pulse and saturates.
- game_over is sticky and clears only on reset. Locks are still accepted after game-over.

## Timing
- Reset (async, Reset_n low): all rows 0, state IDLE, lock_ready=1, busy=0, clear_pulse=0, lines_cleared=0, game_over=0. Reset mid-SCAN or mid-SHIFT aborts immediately with the same values.
- Lock accepted on edge N:
  - Cell is visible on rd_data after edge N.
  - busy=1 and lock_ready=0 from edge N until the FSM returns to IDLE.
- Latency with no full rows: BOARD_ROWS cycles, so IDLE is re-entered after edge N+BOARD_ROWS.
- Each full row at index r adds 1 SCAN cycle plus max(r,1) SHIFT cycles.
- rd_data is a combinational read of current storage. While busy it shows intermediate shift states; consumers must gate on !busy.
- clear_pulse is registered: high in the cycle after the SCAN cycle that detected the row.
- lock_valid while busy is not accepted. The upstream source must hold the request, and no request is lost.

## Configuration
- BOARD_ROW_CLEAR_SCORE_EN defined: lines_cleared counter present as specified.
- BOARD_ROW_CLEAR_SCORE_EN not defined: the counter is removed and lines_cleared is tied to 0. clear_pulse, row removal and game_over are unchanged.

## Structure
- Package board_pkg holds:
  - BOARD_COLS_DEF = 12 and BOARD_ROWS_DEF = 18 defaults
  - typedef row_t = logic [15:0]
  - enum brc_state_t {IDLE, SCAN, SHIFT}
- Single module, no sub-module needed; the full-row test is a one-line reduction.

## Test plan
- Reset, read rows 0..17 -> all rd_data = 0; lock_ready=1, lines_cleared=0, game_over=0.
- Lock (3,17) -> rd_data(17) = 16'h0008; busy high for exactly 18 cycles; no clear_pulse.
- Lock x=0..11 into row 17, with row 16 = 16'h0005 -> one clear_pulse; row 17 = 16'h0005; row 16 = 0; lines_cleared = 1.
- Rows 16 and 17 both full before the final lock (0,16) -> two clear_pulses and lines_cleared = 2. The board above shifts down by 2 and rows 0..1 read 0.
- Lock (5,0) with no full rows -> game_over=1 after the scan and stays 1; lock (12,3) or (2,18) -> no write, busy stays 0.
- Assert Reset_n mid-SHIFT -> all rows 0, IDLE, counters 0 immediately.
